// File: rtl/bcd_display_converter.sv
// -----------------------------------------------------------------------------
// bcd_display_converter
//
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// feeding the seven-segment digit decoders so values read in decimal.
//
// Optional feature macro: BCD_BLANK_EN
//   defined   : blank_o flags leading-zero digits (digit 0 is never blanked)
//   undefined : blank_o is tied to zero, no blanking logic
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous, active-high reset
//   start_i   request a conversion; only honoured in IDLE
//   bin_i     unsigned binary value, captured on the accepting edge
//   busy_o    high while converting (SHIFT and DONE)
//   done_o    one-cycle pulse, bcd_o/blank_o updated in the same cycle
//   bcd_o     packed BCD, digit i in [4i+3:4i]
//   blank_o   leading-zero flags, one per digit
//
// States
//   state   | meaning
//   IDLE    | waiting for start_i, last result held on bcd_o
//   SHIFT   | one add-3 / shift step per cycle, counter runs WIDTH..1
//   DONE    | result published, done_o high for this cycle only
// -----------------------------------------------------------------------------
module bcd_display_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sh_q, sh_d;
    logic [4*DIGITS-1:0]   scr_q, scr_d, adj;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_ONE) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Double-dabble datapath
    // ---------------------------------------------------------------------
    // Digit-wise add-3 with no carry between nibbles; a digit >= 5 would
    // become >= 10 after the shift, the +3 makes it carry into the next digit.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        sh_d  = sh_q;
        scr_d = scr_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sh_d  = bin_i;
                    scr_d = '0;
                    cnt_d = CNT_INIT;
                end
            end
            S_SHIFT: begin
                {scr_d, sh_d} = {adj[4*DIGITS-2:0], sh_q, 1'b0};
                cnt_d         = cnt_q - CNT_ONE;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs, computed from the upcoming state so they are
    // valid right after the edge that enters that state.
    // ---------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        // Result is captured on the final shift so it appears with done_o.
        if (state_q == S_SHIFT && state_d == S_DONE)
            bcd_d = scr_d;
        else
            bcd_d = bcd_q;
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

`ifdef BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zero_above;

    // Walk down from the most significant digit; a digit is blank while it
    // and everything above it are zero. Digit 0 always shows.
    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) blank_q <= BLANK_RST;
        else       blank_q <= blank_d;
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

endmodule

// File: tb/tb_bcd_display_converter.sv
module tb_bcd_display_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int total = 0;
    int bad   = 0;

    bcd_display_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd),
        .blank_o (blank)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] b;
        b = '0;
`ifdef BCD_BLANK_EN
        if (v < 10)    b[1] = 1'b1;
        if (v < 100)   b[2] = 1'b1;
        if (v < 1000)  b[3] = 1'b1;
        if (v < 10000) b[4] = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [4:0] bl(input logic [4:0] with_macro);
`ifdef BCD_BLANK_EN
        return with_macro;
`else
        return 5'b00000;
`endif
    endfunction

    // Drive Start/Bin at a falling edge, return just after the accepting edge.
    task automatic start_conv(input logic [15:0] v);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Observe one conversion from the accepting edge until Busy drops.
    task automatic observe(input string tag, input logic [19:0] exp_bcd,
                           input logic [4:0] exp_blank, input bit hold,
                           input int mid_k, input logic [15:0] mid_bin);
        int          busy_n  = 0;
        int          done_n  = 0;
        int          done_at = -1;
        logic [19:0] got     = '0;
        logic [4:0]  got_bl  = '0;
        bit          nib_ok;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) start = 1'b0;
            if (k == mid_k) bin = mid_bin;
            if (done === 1'b1) begin
                done_n++;
                done_at = k;
                got     = bcd;
                got_bl  = blank;
            end
            if (busy === 1'b1) busy_n++;
            else break;
        end
        nib_ok = 1'b1;
        for (int d = 0; d < 5; d++)
            if (got[4*d +: 4] > 4'd9) nib_ok = 1'b0;
        chk({tag, ".done_cnt"}, 32'(done_n), 32'd1);
        chk({tag, ".done_lat"}, 32'(done_at), 32'd16);
        chk({tag, ".busy_len"}, 32'(busy_n), 32'd17);
        chk({tag, ".bcd"}, 32'(got), 32'(exp_bcd));
        chk({tag, ".blank"}, 32'(got_bl), 32'(exp_blank));
        chk({tag, ".nib_le9"}, 32'(nib_ok), 32'd1);
        chk({tag, ".bcd_hold"}, 32'(bcd), 32'(exp_bcd));
    endtask

    task automatic idle_watch(input string tag, input int cycles,
                              input logic [19:0] exp_bcd);
        int dn = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk({tag, ".no_done"}, 32'(dn), 32'd0);
        chk({tag, ".bcd_kept"}, 32'(bcd), 32'(exp_bcd));
    endtask

    initial begin
        logic [15:0] sv;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.bcd",   32'(bcd),   32'h0);
        chk("rst.busy",  32'(busy),  32'h0);
        chk("rst.done",  32'(done),  32'h0);
        chk("rst.blank", 32'(blank), 32'(bl(5'b11110)));
        rst = 1'b0;

        start_conv(16'd0);
        observe("zero", 20'h00000, bl(5'b11110), 1'b0, -1, 16'd0);

        start_conv(16'hFFFF);
        observe("max", 20'h65535, bl(5'b00000), 1'b0, -1, 16'd0);

        // Start held high: bin changes right away, second accept at first IDLE edge.
        start_conv(16'd1234);
        observe("held1", 20'h01234, bl(5'b10000), 1'b1, 0, 16'd9);
        @(posedge clk);
        observe("held2", 20'h00009, bl(5'b11110), 1'b0, -1, 16'd0);

        start_conv(16'd4096);
        observe("midbin", 20'h04096, bl(5'b10000), 1'b0, 8, 16'd7);
        idle_watch("midbin", 25, 20'h04096);

        start_conv(16'd42);
        observe("prior", 20'h00042, bl(5'b11100), 1'b0, -1, 16'd0);

        start_conv(16'd500);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 8; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.bcd",  32'(bcd),  32'h0);
        chk("abort.busy", 32'(busy), 32'h0);
        chk("abort.done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_watch("abort", 25, 20'h00000);

        start_conv(16'd500);
        observe("after_rst", 20'h00500, bl(5'b11000), 1'b0, -1, 16'd0);

        // Decade boundaries plus a strided sweep against the decimal model.
        for (int i = 0; i < 210; i++) begin
            case (i)
                0: sv = 16'd9;     1: sv = 16'd10;    2: sv = 16'd99;
                3: sv = 16'd100;   4: sv = 16'd999;   5: sv = 16'd1000;
                6: sv = 16'd9999;  7: sv = 16'd10000; 8: sv = 16'd65534;
                9: sv = 16'd1;
                default: sv = 16'((i * 331 + 17) % 65536);
            endcase
            start_conv(sv);
            observe("sweep", ref_bcd(int'(sv)), ref_blank(int'(sv)), 1'b0, -1, 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
